// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache controller: 8 lines x 4 words,
// whole-line refill over a req/ack memory port, saturating hit/miss counters.
module icache_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int INDEX_W = 3,
    parameter int OFFS_W  = 2,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);
    localparam int BYTE_W   = 2;
    localparam int LINE_LSB = BYTE_W + OFFS_W;
    localparam int TAG_LSB  = LINE_LSB + INDEX_W;
    localparam int TAG_W    = ADDR_W - TAG_LSB;
    localparam int LINES    = 1 << INDEX_W;
    localparam int WORDS    = 1 << OFFS_W;

    typedef enum logic [1:0] {
        LOOKUP = 2'd0,
        RESP   = 2'd1,
        REFILL = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [DATA_W-1:0]  data_r [LINES][WORDS];
    logic [TAG_W-1:0]   tag_r [LINES];
    logic [LINES-1:0]   valid_r;
    logic [OFFS_W-1:0]  cnt_r;
    logic [TAG_W-1:0]   refill_tag_r;
    logic [INDEX_W-1:0] refill_idx_r;
    logic               post_refill_r;

    logic [OFFS_W-1:0]  off_s;
    logic [INDEX_W-1:0] idx_s;
    logic [TAG_W-1:0]   tag_s;
    logic               hit_s;
    logic               lookup_hit_s;
    logic               lookup_miss_s;
    logic               fill_s;
    logic               fill_last_s;
    logic               unused_s;

    // Address decode and tag compare against the presented processor address.
    always_comb begin
        off_s    = addr[LINE_LSB-1:BYTE_W];
        idx_s    = addr[TAG_LSB-1:LINE_LSB];
        tag_s    = addr[ADDR_W-1:TAG_LSB];
        hit_s    = valid_r[idx_s] && (tag_r[idx_s] == tag_s);
        unused_s = ^addr[BYTE_W-1:0];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= LOOKUP;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            LOOKUP: begin
                if (hit_s) begin
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = REFILL;
                end
            end
            RESP: begin
                state_nxt_s = LOOKUP;
            end
            REFILL: begin
                if (fill_last_s) begin
                    state_nxt_s = LOOKUP;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = LOOKUP;
            end
        endcase
    end

    // Per-state action strobes; mem_ack only counts while a request is open.
    always_comb begin
        lookup_hit_s  = 1'b0;
        lookup_miss_s = 1'b0;
        fill_s        = 1'b0;
        fill_last_s   = 1'b0;
        case (state_r)
            LOOKUP: begin
                lookup_hit_s  = hit_s;
                lookup_miss_s = ~hit_s;
            end
            REFILL: begin
                fill_s      = mem_ack & mem_req;
                fill_last_s = mem_ack & mem_req & (cnt_r == {OFFS_W{1'b1}});
            end
            default: begin
                lookup_hit_s = 1'b0;
            end
        endcase
    end

    // Registered outputs, valid bits, refill bookkeeping and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid        <= 1'b0;
            rdata         <= {DATA_W{1'b0}};
            mem_req       <= 1'b0;
            mem_addr      <= {ADDR_W{1'b0}};
            hit_cnt       <= {CNT_W{1'b0}};
            miss_cnt      <= {CNT_W{1'b0}};
            cnt_r         <= {OFFS_W{1'b0}};
            post_refill_r <= 1'b0;
            valid_r       <= {LINES{1'b0}};
            refill_tag_r  <= {TAG_W{1'b0}};
            refill_idx_r  <= {INDEX_W{1'b0}};
        end else begin
            rvalid <= lookup_hit_s;
            if (lookup_hit_s) begin
                rdata <= data_r[idx_s][off_s];
                // The re-lookup that completes a miss is not a second event.
                if (!post_refill_r && (hit_cnt != {CNT_W{1'b1}})) begin
                    hit_cnt <= hit_cnt + CNT_W'(1'b1);
                end
                post_refill_r <= 1'b0;
            end
            if (lookup_miss_s) begin
                mem_req      <= 1'b1;
                mem_addr     <= {tag_s, idx_s, {LINE_LSB{1'b0}}};
                cnt_r        <= {OFFS_W{1'b0}};
                refill_tag_r <= tag_s;
                refill_idx_r <= idx_s;
                if (miss_cnt != {CNT_W{1'b1}}) begin
                    miss_cnt <= miss_cnt + CNT_W'(1'b1);
                end
            end
            if (fill_s) begin
                if (fill_last_s) begin
                    mem_req                <= 1'b0;
                    valid_r[refill_idx_r]  <= 1'b1;
                    post_refill_r          <= 1'b1;
                end else begin
                    cnt_r    <= cnt_r + OFFS_W'(1'b1);
                    mem_addr <= mem_addr + ADDR_W'(3'd4);
                end
            end
        end
    end

    // Tag and data arrays carry no reset; the valid bits guard them.
    always_ff @(posedge clk) begin
        if (!rst && fill_s) begin
            data_r[refill_idx_r][cnt_r] <= mem_rdata;
            if (fill_last_s) begin
                tag_r[refill_idx_r] <= refill_tag_r;
            end
        end
    end

endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl: directed scenarios plus random reads,
// compared against a line-address cache model and a hashed memory image.
module tb_icache_ctrl;
    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        rvalid;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    int total = 0;
    int bad = 0;
    int exp_hit = 0;
    int exp_miss = 0;
    int refill_words = 0;
    logic [31:0] mem_seed;
    logic        m_valid [8];
    logic [27:0] m_line [8];

    icache_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ({a[31:2], 2'b00} * 32'h9E3779B1) ^ mem_seed;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_line[i]  = 28'd0;
        end
        exp_hit  = 0;
        exp_miss = 0;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        mem_ack = 1'b0;
        addr    = 32'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
    endtask

    // One processor read; returns after the RESP cycle so the next read starts in lookup.
    task automatic do_read(input logic [31:0] a, input int stall);
        logic        exp_hit_l;
        logic        got;
        logic [2:0]  idx;
        logic [31:0] line_base;
        int lat, words, req_cyc, waitc;
        idx       = a[6:4];
        line_base = {a[31:4], 4'b0000};
        exp_hit_l = m_valid[idx] && (m_line[idx] == a[31:4]);
        addr    = a;
        mem_ack = 1'b0;
        lat = 0; words = 0; req_cyc = 0; waitc = 0; got = 1'b0;
        while (!got && lat < 500) begin
            @(posedge clk); #1;
            lat++;
            mem_ack = 1'b0;
            if (rvalid === 1'b1) begin
                got = 1'b1;
            end else if (mem_req === 1'b1) begin
                req_cyc++;
                chk("mem_addr", mem_addr, line_base + 32'(words * 4));
                if (waitc == stall) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_word(line_base + 32'(words * 4));
                    words++;
                    waitc = 0;
                end else begin
                    waitc++;
                end
            end
        end
        mem_ack = 1'b0;
        refill_words += words;
        chk("rvalid_seen", 32'(got), 32'd1);
        chk("rdata", rdata, mem_word(a));
        chk("latency", 32'(lat + 1), exp_hit_l ? 32'd2 : 32'(7 + 4 * stall));
        chk("refill_words", 32'(words), exp_hit_l ? 32'd0 : 32'd4);
        chk("req_cycles", 32'(req_cyc), exp_hit_l ? 32'd0 : 32'(4 * (stall + 1)));
        if (exp_hit_l) begin
            exp_hit = (exp_hit == 65535) ? 65535 : exp_hit + 1;
        end else begin
            exp_miss     = (exp_miss == 65535) ? 65535 : exp_miss + 1;
            m_valid[idx] = 1'b1;
            m_line[idx]  = a[31:4];
        end
        @(posedge clk); #1;
        chk("rvalid_pulse", 32'(rvalid), 32'd0);
        chk("hit_cnt", 32'(hit_cnt), 32'(exp_hit));
        chk("miss_cnt", 32'(miss_cnt), 32'(exp_miss));
    endtask

    initial begin
        mem_seed  = $urandom;
        rst       = 1'b1;
        addr      = 32'd0;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        model_clear();

        // Reset state
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_hit_cnt", 32'(hit_cnt), 32'd0);
        chk("rst_miss_cnt", 32'(miss_cnt), 32'd0);
        rst = 1'b0;

        // Cold miss then a hit in the same line
        do_read(32'h0000_0000, 0);
        do_read(32'h0000_0004, 0);
        chk("cold_miss_cnt", 32'(miss_cnt), 32'd1);
        chk("cold_hit_cnt", 32'(hit_cnt), 32'd1);

        // Processor-style sweep, twice
        do_reset();
        refill_words = 0;
        for (int a = 0; a < 32'h80; a += 4) do_read(32'(a), 0);
        chk("sweep1_refill_words", 32'(refill_words), 32'd32);
        refill_words = 0;
        for (int a = 0; a < 32'h80; a += 4) do_read(32'(a), 0);
        chk("sweep2_refill_words", 32'(refill_words), 32'd0);
        chk("sweep_miss_cnt", 32'(miss_cnt), 32'd8);
        chk("sweep_hit_cnt", 32'(hit_cnt), 32'd56);

        // Conflict on index 0
        do_reset();
        do_read(32'h0000_0000, 0);
        do_read(32'h0000_0080, 0);
        do_read(32'h0000_0000, 0);
        chk("conflict_miss_cnt", 32'(miss_cnt), 32'd3);

        // Ack stall of 5 cycles per word
        do_reset();
        do_read(32'h0000_0010, 5);
        do_read(32'h0000_0014, 5);

        // Reset in the middle of a refill, with a concurrent ack
        do_reset();
        addr = 32'h0000_0040;
        @(posedge clk); #1;
        chk("mid_req_open", 32'(mem_req), 32'd1);
        mem_ack = 1'b1; mem_rdata = mem_word(32'h40);
        @(posedge clk); #1;
        mem_rdata = mem_word(32'h44);
        @(posedge clk); #1;
        chk("mid_req_word2", mem_addr, 32'h0000_0048);
        rst = 1'b1;
        mem_rdata = mem_word(32'h48);
        @(posedge clk); #1;
        rst = 1'b0;
        mem_ack = 1'b0;
        chk("mid_rst_mem_req", 32'(mem_req), 32'd0);
        chk("mid_rst_mem_addr", mem_addr, 32'd0);
        chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
        chk("mid_rst_hit_cnt", 32'(hit_cnt), 32'd0);
        chk("mid_rst_miss_cnt", 32'(miss_cnt), 32'd0);
        model_clear();
        do_read(32'h0000_0040, 0);
        chk("reread_miss_cnt", 32'(miss_cnt), 32'd1);

        // Random reads across several tags with random ack stalls
        do_reset();
        for (int i = 0; i < 60; i++) begin
            do_read(32'($urandom_range(0, 255)) << 2, int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/icache_ctrl.md
Name: icache_ctrl

Overview:
- Direct-mapped, read-only cache controller between the address-generating processor stage and backing memory.
- Accepts a byte address from the processor and returns the 32-bit word with a one-cycle `rvalid` pulse. The processor advances its address on the cycle `rvalid` is high.
- On a miss it refills the whole line from memory, one word at a time, over a req/ack handshake.
- Keeps saturating hit and miss counters for performance checks.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, word width; fixed 4-byte words.
- INDEX_W, 3, line index bits (8 lines).
- OFFS_W, 2, word-in-line bits (4 words/line, 16 bytes/line).
- CNT_W, 16, hit/miss counter width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- addr  in  ADDR_W  processor byte address; held stable by processor until rvalid.
- rdata  out  DATA_W  returned word; valid when rvalid=1.
- rvalid  out  1  one-cycle pulse: rdata corresponds to current addr.
- mem_req  out  1  memory read request; held until mem_ack.
- mem_addr  out  ADDR_W  word-aligned memory address; stable while mem_req=1.
- mem_ack  in  1  memory accepts request; mem_rdata valid same cycle.
- mem_rdata  in  DATA_W  memory read data.
- hit_cnt  out  CNT_W  number of hits, saturating.
- miss_cnt  out  CNT_W  number of misses, saturating.

Behaviour:
- Address split:
  - addr[1:0] ignored (word access).
  - Word offset: addr[3:2].
  - Index: addr[6:4].
  - Tag: addr[ADDR_W-1:7].
- Storage: 8 lines x 4 words data array; per-line tag and valid bit.
- Reset, on a clk edge with rst=1:
  - All valid bits cleared.
  - State=LOOKUP.
  - rvalid=0, rdata=0, mem_req=0, mem_addr=0, hit_cnt=0, miss_cnt=0, refill word counter=0, post-refill flag=0.
  - Tag/data contents need no reset.
- FSM states: LOOKUP, RESP, REFILL.
- LOOKUP, hit (valid[idx] and tag match):
  - Next edge: rdata<=word, rvalid<=1, state->RESP.
  - hit_cnt+1 unless the post-refill flag is set; flag cleared.
- LOOKUP, miss:
  - Next edge: state->REFILL, mem_req<=1, mem_addr<={tag,idx,4'b0}, word counter<=0.
  - miss_cnt+1; request tag/index latched.
- RESP:
  - rvalid=1 for exactly this cycle.
  - Next edge: rvalid<=0, state->LOOKUP.
  - Back-to-back hits therefore give one rvalid every 2 cycles.
- REFILL, each edge with mem_ack=1:
  - data[idx][cnt]<=mem_rdata.
  - If cnt<3: cnt+1, mem_addr+4, mem_req stays 1.
  - If cnt==3: mem_req<=0, valid[idx]<=1, tag[idx]<=latched tag, post-refill flag<=1, state->LOOKUP.
- REFILL, mem_ack=0: hold mem_req and mem_addr unchanged (any number of stall cycles).
- mem_ack while mem_req=0: ignored.
- Miss latency:
  - With ack on the first cycle of each request: rvalid is seen 7 cycles after the addr lookup (1 miss + 4 refill + 1 re-lookup + 1 RESP).
  - Each ack stall cycle adds 1.
- Eviction: a refill overwrites the line unconditionally. Read-only, so no write-back.
- Counters: saturate at all-ones, no wrap.
- addr changing while state≠LOOKUP is a protocol violation. The controller uses the latched refill tag/index, and the re-lookup uses the addr presented then.
- rst during REFILL: abandon the refill at that edge. mem_req=0 on the next cycle, and the partially filled line stays invalid.
- rst takes priority over every other event in the same cycle.

Test Plan:
- Cold miss, addr=0x00, mem_ack immediate:
  - mem_addr sequence 0x00,0x04,0x08,0x0C with mem_req high 4 cycles.
  - rvalid pulse 7 cycles after lookup, rdata=mem word @0x00.
  - miss_cnt=1, hit_cnt=0.
- After the cold miss, addr=0x04 → hit: rvalid 2 cycles later, rdata=word @0x04, no mem_req, hit_cnt=1.
- Processor-style sweep 0x00..0x7C twice (advance on rvalid):
  - First pass: exactly 8 refills.
  - Second pass: 0 refills.
  - Final counters: miss_cnt=8, hit_cnt=56.
- Conflict: read 0x00, then 0x80 (same index 0), then 0x00:
  - 3 misses, each with a full 4-word refill.
  - rdata matches memory each time.
- Ack stall: delay each mem_ack by 5 cycles.
  - mem_req and mem_addr stable throughout each stall.
  - rvalid arrives 20 cycles later than in the no-stall case.
- Reset asserted after 2 of 4 refill words:
  - mem_req=0 next cycle; rvalid=0, counters=0.
  - Re-reading the same addr causes a full refill (miss_cnt=1).
